// File: rtl/pcs64b66b_pkg.sv
// Shared 64b/66b PCS constants and the beat bundle.
// Header values, block/payload widths and descrambler taps.
package pcs64b66b_pkg;

  localparam int BLOCK_W   = 66;
  localparam int PAYLOAD_W = 64;
  localparam int HIST_W    = 58;
  localparam int TAP_A     = 39;
  localparam int TAP_B     = 58;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef struct packed {
    logic [1:0]           sh;
    logic [PAYLOAD_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/descrambler_64b58.sv
// Self-synchronizing descrambler 1 + x^39 + x^58, 64 bits per beat.
// Ports: clk, reset (sync, high), en (advance history), din, dout.
module descrambler_64b58
  import pcs64b66b_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [PAYLOAD_W-1:0] din,
  output logic [PAYLOAD_W-1:0] dout
);

  logic [HIST_W-1:0]           hist_q;
  logic [HIST_W-1:0]           hist_d;
  logic [HIST_W+PAYLOAD_W-1:0] ext;

  // ext[j] is wire bit j-58 relative to this block; hist_q[57] is newest.
  always_comb begin
    ext    = {din, hist_q};
    dout   = '0;
    hist_d = hist_q;
    for (int k = 0; k < PAYLOAD_W; k++) begin
      dout[k] = ext[k+HIST_W]
              ^ ext[k+HIST_W-TAP_A]
              ^ ext[k+HIST_W-TAP_B];
    end
    if (en) begin
      hist_d = ext[HIST_W+PAYLOAD_W-1 -: HIST_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/decoder_64b66b.sv
// 64b/66b RX block decoder: header split, descramble, skid slice.
// Ports: s_axis_* (66b block in), m_axis_* (type + 64b out).
// Macro DECODER64B66B_DESCRAMBLE_EN enables the descrambler.
module decoder_64b66b
  import pcs64b66b_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BLOCK_W-1:0]   s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [1:0]           m_axis_ttype,
  output logic [PAYLOAD_W-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
);

  logic                 in_fire;
  logic [PAYLOAD_W-1:0] payload_in;
  logic [PAYLOAD_W-1:0] payload_dsc;
  beat_t                in_beat;

  beat_t out_q, out_d;
  logic  out_valid_q, out_valid_d;
  beat_t skid_q, skid_d;
  logic  skid_valid_q, skid_valid_d;

  assign payload_in = s_axis_tdata[BLOCK_W-1:2];
  assign in_fire    = s_axis_tvalid && s_axis_tready;

`ifdef DECODER64B66B_DESCRAMBLE_EN
  descrambler_64b58 u_dsc (
    .clk   (clk),
    .reset (reset),
    .en    (in_fire),
    .din   (payload_in),
    .dout  (payload_dsc)
  );
`else
  assign payload_dsc = payload_in;
`endif

  assign in_beat.sh   = s_axis_tdata[1:0];
  assign in_beat.data = payload_dsc;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      // input is blocked; drain skid into output when it frees
      if (m_axis_tready) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid_q || m_axis_tready) begin
        out_d       = in_beat;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = in_beat;
        skid_valid_d = 1'b1;
      end
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign s_axis_tready = !skid_valid_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = reset ? '0 : out_q.data;
  assign m_axis_ttype  = reset ? 2'b00 : out_q.sh;

endmodule

// File: tb/tb_decoder_64b66b.sv
// Scoreboard bench for decoder_64b66b.
// Directed vectors, stall, random scrambled stream, mid-stream reset.
module tb_decoder_64b66b;
  import pcs64b66b_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [65:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  m_type;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;

`ifdef DECODER64B66B_DESCRAMBLE_EN
  localparam bit DESC = 1'b1;
`else
  localparam bit DESC = 1'b0;
`endif

  decoder_64b66b dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .m_axis_ttype  (m_type),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          accepted = 0;
  logic [65:0] expq[$];
  logic [57:0] scr;
  logic        drv_done;
  logic        prev_stall = 1'b0;
  logic [65:0] prev_beat;

  task automatic chk(input string name, input logic [65:0] act,
                     input logic [65:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] pick(input logic [63:0] dsc,
                                       input logic [63:0] raw);
    return DESC ? dsc : raw;
  endfunction

  // bit-serial reference scrambler; scr[0] is the newest bit
  task automatic scramble(input logic [63:0] d, output logic [63:0] s);
    logic b;
    for (int k = 0; k < 64; k++) begin
      b    = d[k] ^ scr[TAP_A-1] ^ scr[TAP_B-1];
      s[k] = b;
      scr  = {scr[56:0], b};
    end
  endtask

  // entered and left at posedge+1
  task automatic send(input logic [1:0] h, input logic [63:0] p,
                      input logic [63:0] e);
    int t = 0;
    s_valid = 1'b1;
    s_data  = {p, h};
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 500) begin
        $display("FAIL send_timeout: got ready 0 expected 1");
        $fatal(1);
      end
      @(posedge clk); #1;
    end
    expq.push_back({e, h});
    accepted++;
    @(posedge clk); #1;
  endtask

  task automatic send_scr(input logic [1:0] h, input logic [63:0] d);
    logic [63:0] s;
    scramble(d, s);
    send(h, s, pick(d, s));
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (expq.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", 66'(expq.size()), 66'd0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    expq.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_tvalid", 66'(m_valid), 66'd0);
    chk("rst_tdata", 66'(m_data), 66'd0);
    chk("rst_ttype", 66'(m_type), 66'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    scr   = '0;
    @(negedge clk);
    chk("rst_tready", 66'(s_ready), 66'd1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_stable", {m_data, m_type}, prev_beat);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL extra_beat: got %h expected none",
                   {m_data, m_type});
        end else begin
          chk("beat", {m_data, m_type}, expq.pop_front());
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_data, m_type};
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    scr     = '0;
    do_reset();

    send(SH_DATA, 64'h0, 64'h0);
    s_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", 66'(m_valid), 66'd1);
    @(posedge clk); #1;
    send(SH_DATA, 64'h0000_0000_0200_0000, 64'h0000_0000_0200_0000);
    send(SH_DATA, 64'h0, pick(64'h0000_0000_0008_0001, 64'h0));
    send(2'b00, 64'h0000_0000_0200_0000, 64'h0000_0000_0200_0000);
    send(2'b11, 64'h0, pick(64'h0000_0000_0008_0001, 64'h0));
    send(SH_CTRL, 64'h0, 64'h0);
    idle(3);
    wait_drain();

    do_reset();
    m_ready  = 1'b0;
    accepted = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send_scr(i[0] ? SH_CTRL : SH_DATA,
                   {32'hA5A5_0000 + 32'(i), 32'h1234_5678 * 32'(i)});
        s_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_absorbed", 66'(accepted), 66'd2);
        chk("stall_tready", 66'(s_ready), 66'd0);
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_drain();
    chk("stall_count", 66'(accepted), 66'd10);

    do_reset();
    drv_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send_scr(2'($urandom_range(0, 3)), {$urandom, $urandom});
        end
        s_valid  = 1'b0;
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    wait_drain();

    m_ready = 1'b0;
    send(SH_DATA, 64'hDEAD_BEEF_0123_4567, 64'h0);
    send(SH_DATA, 64'h0000_0000_0200_0000, 64'h0);
    s_valid = 1'b0;
    @(negedge clk);
    chk("held_tready", 66'(s_ready), 66'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    expq.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_tvalid", 66'(m_valid), 66'd0);
    chk("midrst_tdata", 66'(m_data), 66'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    send(SH_DATA, 64'h0, 64'h0);
    idle(3);
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/decoder_64b66b.md
# decoder_64b66b

Receive-side 64b/66b block decoder between the PCS gearbox/block aligner and the MAC-side XGMII adapter. Accepts one 66-bit block per beat on an AXI-Stream sink and separates the 2-bit sync header from the 64-bit payload. Descrambles the payload with the IEEE 802.3 self-synchronizing descrambler (1 + x^39 + x^58). Emits the header as a type sideband with the 64-bit payload on an AXI-Stream source, with full backpressure support.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  66  [1:0] sync header, [65:2] scrambled payload; payload bit 2 is first on the wire
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  decoder can accept a beat
- m_axis_ttype  out  2  sync header of the block: 2'b01 data, 2'b10 control, 2'b00/2'b11 illegal
- m_axis_tdata  out  64  descrambled payload; bit 0 = first payload bit on the wire
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream accepts beat

## Operation
- Input transfer occurs when s_axis_tvalid && s_axis_tready. Output transfer occurs when m_axis_tvalid && m_axis_tready.
- Header path: m_axis_ttype = s_axis_tdata[1:0], unchanged.
- Illegal headers are forwarded, not dropped. Block lock and error accounting belong downstream.
- Descrambler:
  - Keeps a 58-bit history of received scrambled bits.
  - For payload bit k (0..63, in wire order): out[k] = in[k] ^ in_stream[k-39] ^ in_stream[k-58].
  - in_stream[n] refers to earlier bits of the same block or to the history.
- History update: after each accepted beat, the history becomes the last 58 scrambled input bits of that beat.
- History does not advance on non-accepted cycles. It advances on every accepted beat, including illegal headers.
- Reset:
  - history = 0
  - m_axis_tvalid = 0
  - skid buffer empty
  - s_axis_tready = 1 in the cycle after reset deasserts
  - m_axis_tdata = 0 and m_axis_ttype = 0 while reset is asserted.
- Reset mid-stream discards all held beats and the descrambler history.
- Datapath:
  - An output register stage plus a one-entry skid buffer.
  - Order is never changed and no beat is duplicated.

## Timing
- Latency: an accepted beat appears on m_axis_* in the next cycle if the output register is empty or is being drained.
- Throughput: one beat per cycle while m_axis_tready = 1.
- s_axis_tready is registered (no combinational path from m_axis_tready). It is 1 exactly when the skid buffer is empty.
- When the output is stalled (m_axis_tvalid = 1, m_axis_tready = 0):
  - An incoming beat is accepted into the skid buffer.
  - s_axis_tready drops on the next cycle.
- When the stall clears, the output register reloads from the skid buffer first. s_axis_tready returns to 1 one cycle later.
- m_axis_* are held stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- Descrambling is done combinationally on the input side before the output register, so the skid buffer stores already-descrambled data.

## Configuration
- DECODER64B66B_DESCRAMBLE_EN defined: descrambler active as described.
- DECODER64B66B_DESCRAMBLE_EN undefined:
  - m_axis_tdata = s_axis_tdata[65:2] unchanged.
  - No history register is built.
  - Handshake and latency are identical to the descrambling build.

## Structure
- Shared package pcs64b66b_pkg holds:
  - header constants SH_DATA = 2'b01, SH_CTRL = 2'b10
  - widths BLOCK_W = 66, PAYLOAD_W = 64
  - descrambler taps TAP_A = 39, TAP_B = 58
- One sub-module: descrambler_64b58 (combinational descramble function plus 58-bit history register with enable).
- Skid/register slice stays inline.

## Test plan
- After reset, send header 2'b01, payload 64'h0 -> one cycle later ttype 2'b01, tdata 64'h0.
- Send payload 64'h0000_0000_0200_0000, then payload 64'h0 -> outputs 64'h0000_0000_0200_0000, then 64'h0000_0000_0008_0001.
- Header 2'b00 and 2'b11 beats -> forwarded with ttype 2'b00 / 2'b11 and history advanced.
- Hold m_axis_tready = 0 for 5 cycles while streaming 10 beats -> exactly 2 beats absorbed, s_axis_tready = 0 on the following cycle.
  - After release, all 10 beats come out in order, none lost or duplicated.
- Scramble a random 1000-block stream with a reference scrambler (same 58-bit state) and feed it with random tvalid/tready gaps -> descrambled payloads and types match the original.
- Assert reset while 2 beats are held -> m_axis_tvalid = 0 next cycle, history cleared.
  - First post-reset zero payload decodes to 64'h0.
